// File: rtl/status_frame_rx.sv
// status_frame_rx: home-status link receiver, sync hunt, field reassembly, checksum check.
// Optional sequence checking is enabled by defining RX_SEQ_CHECK_EN.
module status_frame_rx #(
    parameter int unsigned TIMEOUT = 15,
    parameter logic [5:0]  SYNC    = 6'b101101
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] data,
    input  logic       data_valid,
    output logic       data_ready,
    output logic       lights,
    output logic       plugs,
    output logic [4:0] temperature,
    output logic       update,
    output logic       changed,
    output logic       err_chk,
    output logic       err_seq,
    output logic       err_timeout
);

    localparam logic [1:0] HUNT       = 2'd0;
    localparam logic [1:0] GOT_SYNC   = 2'd1;
    localparam logic [1:0] GOT_STATUS = 2'd2;
    localparam logic [1:0] COMMIT     = 2'd3;

    localparam logic [7:0] TMO = 8'(TIMEOUT);

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic [7:0] tcnt;
    logic [5:0] w1_q;
    logic       t0_q;
    logic       accept;
    logic       in_frame;
    logic       expire;
    logic       chk_ok;
    logic       load_w1;
    logic       load_w2;
    logic       chk_fail;
    logic       new_lights;
    logic       new_plugs;
    logic [4:0] new_temp;
    logic       seq_bad;

    assign data_ready = !rst && (state != COMMIT);
    assign accept     = data_valid && data_ready;
    assign in_frame   = (state == GOT_SYNC) || (state == GOT_STATUS);
    assign expire     = in_frame && (tcnt == TMO);
    assign chk_ok     = data[2:0] == (w1_q[5:3] ^ w1_q[2:0] ^ data[5:3]);

    assign new_lights = w1_q[5];
    assign new_plugs  = w1_q[4];
    assign new_temp   = {w1_q[3:0], t0_q};

    // Next-state and capture decisions; a timeout overrides any offered word.
    always_comb begin
        state_nxt = state;
        load_w1   = 1'b0;
        load_w2   = 1'b0;
        chk_fail  = 1'b0;
        unique case (state)
            HUNT: begin
                if (accept && data == SYNC) state_nxt = GOT_SYNC;
            end
            GOT_SYNC: begin
                if (expire) begin
                    state_nxt = HUNT;
                end else if (accept) begin
                    load_w1   = 1'b1;
                    state_nxt = GOT_STATUS;
                end
            end
            GOT_STATUS: begin
                if (expire) begin
                    state_nxt = HUNT;
                end else if (accept) begin
                    if (chk_ok) begin
                        load_w2   = 1'b1;
                        state_nxt = COMMIT;
                    end else begin
                        chk_fail  = 1'b1;
                        state_nxt = HUNT;
                    end
                end
            end
            COMMIT: begin
                state_nxt = HUNT;
            end
            default: state_nxt = HUNT;
        endcase
    end

    // State register and intra-frame idle counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= HUNT;
            tcnt  <= 8'd0;
        end else begin
            state <= state_nxt;
            if (!in_frame || expire || accept) begin
                tcnt <= 8'd0;
            end else begin
                tcnt <= tcnt + 8'd1;
            end
        end
    end

    // Capture the status word and the low temperature bit of the tail word.
    always_ff @(posedge clk) begin
        if (rst) begin
            w1_q <= 6'd0;
            t0_q <= 1'b0;
        end else begin
            if (load_w1) w1_q <= data;
            if (load_w2) t0_q <= data[5];
        end
    end

`ifdef RX_SEQ_CHECK_EN
    logic [1:0] seq_q;
    logic [1:0] seq_rx_q;

    assign seq_bad = seq_rx_q != (seq_q + 2'd1);

    // Track received sequence number; resync to whatever was committed.
    always_ff @(posedge clk) begin
        if (rst) begin
            seq_q    <= 2'd3;
            seq_rx_q <= 2'd0;
        end else begin
            if (load_w2)          seq_rx_q <= data[4:3];
            if (state == COMMIT)  seq_q    <= seq_rx_q;
        end
    end
`else
    assign seq_bad = 1'b0;
`endif

    // Output registers and one-cycle status pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            lights      <= 1'b0;
            plugs       <= 1'b0;
            temperature <= 5'd0;
            update      <= 1'b0;
            changed     <= 1'b0;
            err_chk     <= 1'b0;
            err_seq     <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            update      <= 1'b0;
            changed     <= 1'b0;
            err_seq     <= 1'b0;
            err_chk     <= chk_fail;
            err_timeout <= expire;
            if (state == COMMIT) begin
                lights      <= new_lights;
                plugs       <= new_plugs;
                temperature <= new_temp;
                update      <= 1'b1;
                changed     <= {new_lights, new_plugs, new_temp} !=
                               {lights, plugs, temperature};
                err_seq     <= seq_bad;
            end
        end
    end

endmodule

// File: tb/tb_status_frame_rx.sv
// tb_status_frame_rx: directed-vector bench for the status link receiver.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_status_frame_rx;

    localparam logic [5:0] SW   = 6'b101101;
    localparam logic [5:0] F1A  = 6'b111111;
    localparam logic [5:0] F1B  = 6'b100100;
    localparam logic [5:0] F2A  = 6'b001100;
    localparam logic [5:0] F2B  = 6'b101000;
    localparam logic [5:0] BADB = 6'b100000;

    logic       clk;
    logic       rst;
    logic [5:0] data;
    logic       data_valid;
    logic       data_ready;
    logic       lights;
    logic       plugs;
    logic [4:0] temperature;
    logic       update;
    logic       changed;
    logic       err_chk;
    logic       err_seq;
    logic       err_timeout;

    int pass_cnt  = 0;
    int total_cnt = 0;

    status_frame_rx dut (
        .clk         (clk),
        .rst         (rst),
        .data        (data),
        .data_valid  (data_valid),
        .data_ready  (data_ready),
        .lights      (lights),
        .plugs       (plugs),
        .temperature (temperature),
        .update      (update),
        .changed     (changed),
        .err_chk     (err_chk),
        .err_seq     (err_seq),
        .err_timeout (err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic v, input logic [5:0] w);
        @(negedge clk);
        data_valid = v;
        data       = w;
    endtask

    task automatic test_reset;
        drive(1'b0, 6'd0);
        total_cnt++;
        if (data_ready !== 1'b0) $display("FAIL rst_ready got %b want 0", data_ready);
        else pass_cnt++;
        total_cnt++;
        if ({lights, plugs, temperature} !== 7'd0)
            $display("FAIL rst_outputs got %b want 0", {lights, plugs, temperature});
        else pass_cnt++;
        total_cnt++;
        if ({update, changed, err_chk, err_seq, err_timeout} !== 5'd0)
            $display("FAIL rst_pulses got %b want 0",
                     {update, changed, err_chk, err_seq, err_timeout});
        else pass_cnt++;
        rst = 1'b0;
        drive(1'b0, 6'd0);
        total_cnt++;
        if (data_ready !== 1'b1) $display("FAIL rst_release_ready got %b want 1", data_ready);
        else pass_cnt++;
    endtask

    task automatic test_first_frame;
        drive(1'b1, SW);
        drive(1'b1, F1A);
        drive(1'b1, F1B);
        drive(1'b1, SW);
        total_cnt++;
        if (data_ready !== 1'b0) $display("FAIL f1_commit_ready got %b want 0", data_ready);
        else pass_cnt++;
        total_cnt++;
        if (update !== 1'b0) $display("FAIL f1_early_update got %b want 0", update);
        else pass_cnt++;
        drive(1'b1, SW);
        total_cnt++;
        if (update !== 1'b1) $display("FAIL f1_update got %b want 1", update);
        else pass_cnt++;
        total_cnt++;
        if (changed !== 1'b1) $display("FAIL f1_changed got %b want 1", changed);
        else pass_cnt++;
        total_cnt++;
        if (err_seq !== 1'b0) $display("FAIL f1_err_seq got %b want 0", err_seq);
        else pass_cnt++;
        total_cnt++;
        if ({lights, plugs, temperature} !== {1'b1, 1'b1, 5'd31})
            $display("FAIL f1_fields got %b want %b",
                     {lights, plugs, temperature}, {1'b1, 1'b1, 5'd31});
        else pass_cnt++;
        total_cnt++;
        if (data_ready !== 1'b1) $display("FAIL f1_ready_after got %b want 1", data_ready);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back;
        drive(1'b1, F2A);
        total_cnt++;
        if (update !== 1'b0) $display("FAIL b2b_pulse_width got %b want 0", update);
        else pass_cnt++;
        drive(1'b1, F2B);
        drive(1'b0, 6'd0);
        total_cnt++;
        if (data_ready !== 1'b0) $display("FAIL b2b_commit_ready got %b want 0", data_ready);
        else pass_cnt++;
        drive(1'b0, 6'd0);
        total_cnt++;
        if ({update, changed} !== 2'b11)
            $display("FAIL b2b_update_changed got %b want 11", {update, changed});
        else pass_cnt++;
        total_cnt++;
        if ({lights, plugs, temperature} !== {1'b0, 1'b0, 5'd25})
            $display("FAIL b2b_fields got %b want %b",
                     {lights, plugs, temperature}, {1'b0, 1'b0, 5'd25});
        else pass_cnt++;
        drive(1'b0, 6'd0);
        total_cnt++;
        if ({update, data_ready} !== 2'b01)
            $display("FAIL b2b_after got %b want 01", {update, data_ready});
        else pass_cnt++;
    endtask

    task automatic test_bad_chk;
        drive(1'b1, SW);
        drive(1'b1, F1A);
        drive(1'b1, BADB);
        drive(1'b0, 6'd0);
        total_cnt++;
        if ({err_chk, update, data_ready} !== 3'b101)
            $display("FAIL chk_pulse got %b want 101", {err_chk, update, data_ready});
        else pass_cnt++;
        drive(1'b0, 6'd0);
        total_cnt++;
        if ({err_chk, update} !== 2'b00)
            $display("FAIL chk_after got %b want 00", {err_chk, update});
        else pass_cnt++;
        total_cnt++;
        if ({lights, plugs, temperature} !== {1'b0, 1'b0, 5'd25})
            $display("FAIL chk_hold got %b want %b",
                     {lights, plugs, temperature}, {1'b0, 1'b0, 5'd25});
        else pass_cnt++;
        drive(1'b1, SW);
        drive(1'b1, F1A);
        drive(1'b1, F1B);
        drive(1'b0, 6'd0);
        drive(1'b0, 6'd0);
        total_cnt++;
        if ({update, changed, lights, plugs, temperature} !== {4'b1111, 5'd31})
            $display("FAIL chk_recover got %b want %b",
                     {update, changed, lights, plugs, temperature}, {4'b1111, 5'd31});
        else pass_cnt++;
    endtask

    task automatic test_garbage;
        drive(1'b1, 6'b000000);
        drive(1'b1, 6'b010101);
        drive(1'b1, SW);
        total_cnt++;
        if (update !== 1'b0) $display("FAIL garbage_update got %b want 0", update);
        else pass_cnt++;
        drive(1'b1, F1A);
        drive(1'b1, F1B);
        drive(1'b0, 6'd0);
        total_cnt++;
        if (update !== 1'b0) $display("FAIL garbage_early got %b want 0", update);
        else pass_cnt++;
        drive(1'b0, 6'd0);
        total_cnt++;
        if ({update, changed} !== 2'b10)
            $display("FAIL garbage_same got %b want 10", {update, changed});
        else pass_cnt++;
        total_cnt++;
        if ({lights, plugs, temperature} !== {1'b1, 1'b1, 5'd31})
            $display("FAIL garbage_fields got %b want %b",
                     {lights, plugs, temperature}, {1'b1, 1'b1, 5'd31});
        else pass_cnt++;
    endtask

    task automatic test_timeout;
        drive(1'b1, SW);
        drive(1'b1, F1A);
        for (int i = 0; i < 15; i++) drive(1'b0, 6'd0);
        total_cnt++;
        if (err_timeout !== 1'b0) $display("FAIL tmo_early got %b want 0", err_timeout);
        else pass_cnt++;
        drive(1'b1, F1B);
        total_cnt++;
        if ({data_ready, err_timeout} !== 2'b10)
            $display("FAIL tmo_expiry_cycle got %b want 10", {data_ready, err_timeout});
        else pass_cnt++;
        drive(1'b0, 6'd0);
        total_cnt++;
        if ({err_timeout, update} !== 2'b10)
            $display("FAIL tmo_pulse got %b want 10", {err_timeout, update});
        else pass_cnt++;
        drive(1'b0, 6'd0);
        total_cnt++;
        if ({err_timeout, update} !== 2'b00)
            $display("FAIL tmo_after got %b want 00", {err_timeout, update});
        else pass_cnt++;
        drive(1'b0, 6'd0);
        total_cnt++;
        if (update !== 1'b0) $display("FAIL tmo_w2_dropped got %b want 0", update);
        else pass_cnt++;
        drive(1'b1, SW);
        drive(1'b1, F2A);
        drive(1'b1, F2B);
        drive(1'b0, 6'd0);
        drive(1'b0, 6'd0);
        total_cnt++;
        if ({update, changed, lights, plugs, temperature} !== {4'b1100, 5'd25})
            $display("FAIL tmo_recover got %b want %b",
                     {update, changed, lights, plugs, temperature}, {4'b1100, 5'd25});
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_frame;
        drive(1'b1, SW);
        drive(1'b1, F1A);
        @(negedge clk);
        rst        = 1'b1;
        data_valid = 1'b0;
        @(negedge clk);
        total_cnt++;
        if ({data_ready, lights, plugs, temperature} !== 8'd0)
            $display("FAIL mid_rst_state got %b want 0",
                     {data_ready, lights, plugs, temperature});
        else pass_cnt++;
        rst = 1'b0;
        drive(1'b1, F1B);
        drive(1'b0, 6'd0);
        drive(1'b0, 6'd0);
        total_cnt++;
        if (update !== 1'b0) $display("FAIL mid_rst_partial got %b want 0", update);
        else pass_cnt++;
        drive(1'b1, SW);
        drive(1'b1, F1A);
        drive(1'b1, F1B);
        drive(1'b0, 6'd0);
        drive(1'b0, 6'd0);
        total_cnt++;
        if ({update, changed, err_seq} !== 3'b110)
            $display("FAIL mid_rst_frame got %b want 110", {update, changed, err_seq});
        else pass_cnt++;
        total_cnt++;
        if ({lights, plugs, temperature} !== {1'b1, 1'b1, 5'd31})
            $display("FAIL mid_rst_fields got %b want %b",
                     {lights, plugs, temperature}, {1'b1, 1'b1, 5'd31});
        else pass_cnt++;
    endtask

`ifdef RX_SEQ_CHECK_EN
    task automatic test_seq_check;
        drive(1'b1, SW);
        drive(1'b1, 6'b010000);
        drive(1'b1, 6'b010000);
        drive(1'b0, 6'd0);
        drive(1'b0, 6'd0);
        total_cnt++;
        if ({update, err_seq} !== 2'b11)
            $display("FAIL seq_skip got %b want 11", {update, err_seq});
        else pass_cnt++;
        total_cnt++;
        if ({lights, plugs, temperature} !== {1'b0, 1'b1, 5'd0})
            $display("FAIL seq_skip_fields got %b want %b",
                     {lights, plugs, temperature}, {1'b0, 1'b1, 5'd0});
        else pass_cnt++;
        drive(1'b1, SW);
        drive(1'b1, 6'b000000);
        drive(1'b1, 6'b011011);
        drive(1'b0, 6'd0);
        drive(1'b0, 6'd0);
        total_cnt++;
        if ({update, err_seq} !== 2'b10)
            $display("FAIL seq_resync got %b want 10", {update, err_seq});
        else pass_cnt++;
    endtask
`endif

    initial begin
        rst        = 1'b1;
        data       = 6'd0;
        data_valid = 1'b0;
        test_reset();
        test_first_frame();
        test_back_to_back();
        test_bad_chk();
        test_garbage();
        test_timeout();
        test_reset_mid_frame();
`ifdef RX_SEQ_CHECK_EN
        test_seq_check();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/status_frame_rx.md
# status_frame_rx

Receive-side decoder for the home-status link. Accepts the 6-bit `data` word stream produced by the status packer, hunts for frame sync, reassembles the lights/plugs/temperature fields, validates a 3-bit checksum, and presents the decoded status as registered outputs. It sits at the far end of the link and feeds the display/control logic.

## Interface
- `TIMEOUT`, 15: maximum idle cycles allowed between words inside a frame; legal range 1–255.
- `SYNC`, 6'b101101: frame sync word.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `data`  in  6  incoming link word.
- `data_valid`  in  1  `data` is valid this cycle.
- `data_ready`  out  1  block can accept a word.
- `lights`  out  1  decoded lights state.
- `plugs`  out  1  decoded plugs state.
- `temperature`  out  5  decoded temperature, unsigned 0–31.
- `update`  out  1  one-cycle pulse when the outputs load a new frame.
- `changed`  out  1  one-cycle pulse, coincident with `update`, if any field differs from its previous value.
- `err_chk`  out  1  one-cycle pulse on a checksum failure.
- `err_seq`  out  1  one-cycle pulse on a sequence error (see Configuration).
- `err_timeout`  out  1  one-cycle pulse when an intra-frame timeout aborts a frame.

## Operation
- A word is accepted on a rising edge with `data_valid && data_ready`.
- Frame format, 3 words:
  - W0 = `SYNC`.
  - W1 = {lights, plugs, temp[4:1]}.
  - W2 = {temp[0], seq[1:0], chk[2:0]}, where chk = W1[5:3] ^ W1[2:0] ^ W2[5:3].
- FSM states: HUNT, GOT_SYNC, GOT_STATUS, COMMIT.
  - HUNT: an accepted word equal to `SYNC` goes to GOT_SYNC; any other word is discarded.
  - GOT_SYNC: the accepted word is latched as W1, with no sync check (a `SYNC`-valued W1 is legal). Go to GOT_STATUS.
  - GOT_STATUS: the accepted word is W2.
    - Checksum good: go to COMMIT.
    - Checksum bad: pulse `err_chk` and go to HUNT; outputs are unchanged.
  - COMMIT: lasts one cycle. Load the outputs, pulse `update` (and `changed` if applicable), store seq, then go to HUNT.
- `data_ready` = !rst && state != COMMIT. It is combinational from registered state.
- Timeout counter (8-bit):
  - Clears on every accepted word and in HUNT/COMMIT.
  - Increments each GOT_SYNC/GOT_STATUS cycle with no accepted word.
  - When it reaches `TIMEOUT`: pulse `err_timeout`, go to HUNT, and discard the partial frame. Outputs are unchanged.
- Timeout takes priority over a word offered in the same cycle; that word is dropped and is not sync-checked.
- `changed` compares {lights, plugs, temperature} against the current output registers before the load.
- Reset mid-frame: the partial frame is discarded and the FSM returns to HUNT.

## Timing
- Reset values: `lights`=0, `plugs`=0, `temperature`=0; `update`, `changed`, `err_*` all 0; `data_ready`=0 while `rst` is high; state HUNT; stored seq=3 (so the first expected seq is 0).
- Latency, W2 accepted at edge N:
  - FSM is in COMMIT during cycle N→N+1, with `data_ready`=0.
  - Outputs and `update` are registered at edge N+1 and visible in cycle N+1→N+2.
- `err_chk` is high in the cycle after the edge that accepted the bad W2.
- `err_timeout` is high in the cycle after the expiring edge.
- Back-to-back frames: the next `SYNC` can be accepted at edge N+2 at the earliest.
- All pulses are exactly one cycle wide.

## Configuration
- `RX_SEQ_CHECK_EN` defined:
  - At COMMIT, if seq != (stored seq + 1) mod 4, pulse `err_seq` coincident with `update`.
  - The frame is still loaded and seq is resynchronised to the received value.
- Not defined: seq is ignored and `err_seq` is tied to 0.

## Test plan
- Frame 101101, 111111, 100100 (lights=1, plugs=1, temp=31, seq=0) -> `update`=1 and `changed`=1 two cycles after the W2 edge; outputs 1/1/31; `err_seq`=0.
- Follow with 101101, 001100, 101000 (0/0/25, seq=1) -> outputs 0/0/25, `changed`=1; `data_ready`=0 only during COMMIT.
- 101101, 111111, 100000 (bad chk) -> `err_chk` pulse; no `update`; outputs hold; the next valid frame decodes normally.
- Garbage 000000, 010101, then a valid frame -> garbage ignored in HUNT; only the valid frame decodes.
- 101101, 111111, then 15 idle cycles -> `err_timeout` pulse; a W2 offered on the expiry cycle is dropped; a following full frame decodes.
- With `RX_SEQ_CHECK_EN`: seq 0 then seq 2 -> second frame loads with `err_seq`=1; reset mid-frame after W1 -> outputs all 0, the next frame decodes.
